regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Initiator-side controller for the synchronous 4-entry register file: accepts read, write and (optionally) read-modify-write commands on a valid/ready request channel. It sequences the register file's shared address/write ports and absorbs the file's one-cycle read latency. It returns results on a valid/ready response channel. It sits between the instruction/operand logic and the register file.

## Interface
- DATA_W, 32, register width
- ADDR_W, 2, register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept (high only in IDLE)
- cmd_op  in  2  00 READ, 01 WRITE, 10 RMW_ADD, 11 reserved
- cmd_addr_a  in  ADDR_W  primary index (read and write target)
- cmd_addr_b  in  ADDR_W  secondary read index
- cmd_data  in  DATA_W  write data / RMW addend
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data_a  out  DATA_W  result A
- rsp_data_b  out  DATA_W  result B
- rsp_err  out  1  illegal/disabled op
- rf_address_a  out  ADDR_W  to register file address_a
- rf_address_b  out  ADDR_W  to register file address_b
- rf_write_enable  out  1  to register file write_enable
- rf_write_data  out  DATA_W  to register file write_data
- rf_data_a  in  DATA_W  from register file, valid one cycle after address
- rf_data_b  in  DATA_W  from register file

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, WB, RESP.
- IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch op/addresses/data; op 00/01/10(enabled) -> ISSUE; op 11 or disabled RMW -> RESP with rsp_err=1, data 0, no regfile access.
- ISSUE: rf_address_a/b = latched addresses; rf_write_enable=1 only for WRITE, rf_write_data=cmd_data -> CAPTURE.
- CAPTURE: register rf_data_a/b into response registers; RMW -> WB, else -> RESP.
- WRITE response: rsp_data_a = prior contents of addr_a (the file reads the old value in the write cycle); rsp_data_b = contents of addr_b (old value if addr_b==addr_a).
- WB: rf_write_enable=1, rf_address_a=addr_a, rf_write_data = captured_a + cmd_data, truncated mod 2^DATA_W (no carry out); rsp_data_a updated to sum -> RESP.
- RESP: rsp_valid=1, rsp_* held stable until rsp_ready; on handshake -> IDLE.
- rf_write_enable is asserted only in ISSUE(WRITE) and WB, for exactly one cycle per command.
- rf_address_* and rf_write_data hold last value when idle; rf_write_enable=0.

## Timing
- Reset (async assert, sync release): state IDLE, cmd_ready=1, rsp_valid=0, rsp_data_a/b=0, rsp_err=0, rf_write_enable=0, rf_address_a/b=0, rf_write_data=0.
- Accept at edge N: ISSUE cycle N+1, CAPTURE N+2, rsp_valid high from N+3 (READ/WRITE), N+4 (RMW), N+1 (error).
- Throughput: one command per response handshake; no overlap, cmd_ready=0 from accept until return to IDLE.
- Reset mid-command: aborts immediately; rf_write_enable drops asynchronously, pending response discarded, no partial RMW write.
- Register file contents are not reset; reads before writes return undefined data.

## Configuration
- REGFILE_CTRL_RMW_EN defined: op 10 performs read-add-write as above.
- Undefined: WB state and adder removed; op 10 treated as illegal (rsp_err=1, no access).

## Structure
- Shared package regfile_ctrl_pkg: op encoding constants, FSM state enum, default DATA_W/ADDR_W.
- Single module; no sub-module. Bench instantiates the register file alongside.

## Test plan
- Reset, WRITE addr 2 data 0xDEADBEEF -> rf_write_enable high exactly one cycle with rf_address_a=2; rsp_valid 3 cycles after accept, rsp_err=0.
- Then READ a=2, b=2 -> rsp_data_a=rsp_data_b=0xDEADBEEF.
- WRITE addr 1 0x11, then WRITE addr 1 0x22 -> second rsp_data_a=0x11; READ a=1 -> 0x22.
- Reg 3=0xFFFFFFFF, RMW addr 3 cmd_data 2 -> reg 3=0x00000001, rsp_data_a=1 at 4 cycles; without macro -> rsp_err=1 after 1 cycle, reg 3 unchanged.
- rsp_ready low 5 cycles during RESP -> rsp_valid/data stable, cmd_ready=0; next command accepted the cycle after handshake.
- Op 11 -> rsp_err=1, no rf_write_enable; rst pulse while in CAPTURE of RMW -> no write to target, all outputs at reset values.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file initiator controller.
// REGFILE_CTRL_RMW_EN enables the read-add-write command (op 10).
package regfile_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RMW   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_WB,
        ST_RESP
    } state_t;

    function automatic logic op_legal(input logic [1:0] op);
`ifdef REGFILE_CTRL_RMW_EN
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_RMW);
`else
        return (op == OP_READ) || (op == OP_WRITE);
`endif
    endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Command and response channels between the operand logic and regfile_ctrl.
interface regfile_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr_a;
    logic [ADDR_W-1:0] cmd_addr_b;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Sequences one command at a time onto the register file ports and returns the result.
// Build with REGFILE_CTRL_RMW_EN to add the WB state and adder for op 10.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// ISSUE   | addresses (and write strobe for WRITE) presented to the file
// CAPTURE | file read data sampled into the response registers
// WB      | read-modify-write sum written back to addr_a
// RESP    | response held until rsp_ready
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    regfile_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] rf_address_a,
    output logic [ADDR_W-1:0] rf_address_b,
    output logic              rf_write_enable,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b
);

    state_t state, state_nx;

`ifdef REGFILE_CTRL_RMW_EN
    logic [1:0]        op_q;
    logic [DATA_W-1:0] addend_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:
                if (bus.cmd_valid)
                    state_nx = op_legal(bus.cmd_op) ? ST_ISSUE : ST_RESP;
            ST_ISSUE:
                state_nx = ST_CAPTURE;
`ifdef REGFILE_CTRL_RMW_EN
            ST_CAPTURE:
                state_nx = (op_q == OP_RMW) ? ST_WB : ST_RESP;
            ST_WB:
                state_nx = ST_RESP;
`else
            ST_CAPTURE:
                state_nx = ST_RESP;
`endif
            ST_RESP:
                if (bus.rsp_ready) state_nx = ST_IDLE;
            default:
                state_nx = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);

    // Port registers only move for legal commands, so they hold their last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_address_a    <= '0;
            rf_address_b    <= '0;
            rf_write_enable <= 1'b0;
            rf_write_data   <= '0;
            bus.rsp_data_a  <= '0;
            bus.rsp_data_b  <= '0;
            bus.rsp_err     <= 1'b0;
`ifdef REGFILE_CTRL_RMW_EN
            op_q            <= OP_READ;
            addend_q        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE:
                    if (bus.cmd_valid) begin
`ifdef REGFILE_CTRL_RMW_EN
                        op_q     <= bus.cmd_op;
                        addend_q <= bus.cmd_data;
`endif
                        if (op_legal(bus.cmd_op)) begin
                            rf_address_a    <= bus.cmd_addr_a;
                            rf_address_b    <= bus.cmd_addr_b;
                            rf_write_data   <= bus.cmd_data;
                            rf_write_enable <= (bus.cmd_op == OP_WRITE);
                            bus.rsp_err     <= 1'b0;
                        end else begin
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_data_a <= '0;
                            bus.rsp_data_b <= '0;
                        end
                    end
                ST_ISSUE:
                    rf_write_enable <= 1'b0;
                ST_CAPTURE: begin
                    bus.rsp_data_a <= rf_data_a;
                    bus.rsp_data_b <= rf_data_b;
`ifdef REGFILE_CTRL_RMW_EN
                    if (op_q == OP_RMW) begin
                        rf_write_enable <= 1'b1;
                        rf_write_data   <= rf_data_a + addend_q;
                    end
`endif
                end
`ifdef REGFILE_CTRL_RMW_EN
                ST_WB: begin
                    rf_write_enable <= 1'b0;
                    bus.rsp_data_a  <= rf_write_data;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomized self-checking bench for regfile_ctrl with a behavioural register file alongside.
module tb_regfile_ctrl;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rf_address_a, rf_address_b;
    logic          rf_write_enable;
    logic [DW-1:0] rf_write_data;
    logic [DW-1:0] rf_data_a, rf_data_b;
    logic [DW-1:0] rf_mem [4];

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural register contents and whether each is defined yet.
    logic [DW-1:0] model_mem [4];
    bit            known [4];

    regfile_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .rf_address_a    (rf_address_a),
        .rf_address_b    (rf_address_b),
        .rf_write_enable (rf_write_enable),
        .rf_write_data   (rf_write_data),
        .rf_data_a       (rf_data_a),
        .rf_data_b       (rf_data_b)
    );

    always #5 clk = ~clk;

    // Synchronous file: one-cycle read latency, read-before-write in the write cycle.
    always @(posedge clk) begin
        if (rf_write_enable) rf_mem[rf_address_a] <= rf_write_data;
        rf_data_a <= rf_mem[rf_address_a];
        rf_data_b <= rf_mem[rf_address_b];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, "_rsp_a"}, 64'(bus.rsp_data_a), 64'(0));
        chk({tag, "_rsp_b"}, 64'(bus.rsp_data_b), 64'(0));
        chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'(0));
        chk({tag, "_we"}, 64'(rf_write_enable), 64'(0));
        chk({tag, "_addr"}, 64'({rf_address_a, rf_address_b}), 64'(0));
        chk({tag, "_wdata"}, 64'(rf_write_data), 64'(0));
    endtask

    function automatic bit rmw_enabled();
`ifdef REGFILE_CTRL_RMW_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                          input logic [31:0] d, input int hold);
        logic [31:0] exp_a, exp_b, exp_wdata;
        bit          exp_err, a_known, b_known;
        int          exp_lat, exp_we, lat, we_cnt, n;
        logic [1:0]  we_addr;
        logic [31:0] we_data;

        exp_err   = (op == 2'b11) || (op == 2'b10 && !rmw_enabled());
        exp_a     = '0;
        exp_b     = '0;
        exp_wdata = '0;
        exp_we    = 0;
        a_known   = 1'b1;
        b_known   = 1'b1;
        if (exp_err) begin
            exp_lat = 1;
        end else begin
            a_known = known[a];
            b_known = known[b];
            exp_a   = model_mem[a];
            exp_b   = model_mem[b];
            exp_lat = 3;
            if (op == 2'b01) begin
                exp_we       = 1;
                exp_wdata    = d;
                model_mem[a] = d;
                known[a]     = 1'b1;
            end else if (op == 2'b10) begin
                exp_we       = 1;
                exp_lat      = 4;
                exp_a        = model_mem[a] + d;
                exp_wdata    = exp_a;
                model_mem[a] = exp_a;
            end
        end

        @(negedge clk);
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_addr_a = a;
        bus.cmd_addr_b = b;
        bus.cmd_data   = d;
        bus.rsp_ready  = 1'b0;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;

        lat     = 0;
        we_cnt  = 0;
        we_addr = '0;
        we_data = '0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (rf_write_enable) begin
                we_cnt++;
                we_addr = rf_address_a;
                we_data = rf_write_data;
            end
            if (bus.rsp_valid || lat >= 10) break;
            chk("busy_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        if (a_known) chk("rsp_a", 64'(bus.rsp_data_a), 64'(exp_a));
        if (b_known) chk("rsp_b", 64'(bus.rsp_data_b), 64'(exp_b));
        chk("we_count", 64'(we_cnt), 64'(exp_we));
        if (exp_we != 0) begin
            chk("we_addr", 64'(we_addr), 64'(a));
            if (op == 2'b01 || a_known) chk("we_data", 64'(we_data), 64'(exp_wdata));
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_ctrl", 64'({bus.rsp_valid, bus.cmd_ready, rf_write_enable, bus.rsp_err}),
                64'({1'b1, 1'b0, 1'b0, exp_err}));
            if (a_known) chk("hold_a", 64'(bus.rsp_data_a), 64'(exp_a));
            if (b_known) chk("hold_b", 64'(bus.rsp_data_b), 64'(exp_b));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  r_op, r_a, r_b;
        logic [31:0] r_d;

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = '0;
        bus.cmd_addr_a = '0;
        bus.cmd_addr_b = '0;
        bus.cmd_data   = '0;
        bus.rsp_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            model_mem[i] = '0;
            known[i]     = 1'b0;
        end

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        do_cmd(2'b01, 2'd2, 2'd0, 32'hDEADBEEF, 0);
        do_cmd(2'b01, 2'd0, 2'd2, 32'h0000_5A5A, 0);
        do_cmd(2'b01, 2'd3, 2'd0, 32'h1234_5678, 0);
        do_cmd(2'b00, 2'd2, 2'd2, 32'h0, 0);
        do_cmd(2'b01, 2'd1, 2'd1, 32'h11, 0);
        do_cmd(2'b01, 2'd1, 2'd1, 32'h22, 0);
        do_cmd(2'b00, 2'd1, 2'd0, 32'h0, 0);
        do_cmd(2'b01, 2'd3, 2'd3, 32'hFFFF_FFFF, 0);
        do_cmd(2'b10, 2'd3, 2'd2, 32'h2, 0);
        do_cmd(2'b00, 2'd3, 2'd1, 32'h0, 0);
        do_cmd(2'b00, 2'd0, 2'd3, 32'h0, 5);
        do_cmd(2'b11, 2'd2, 2'd1, 32'hCAFE_F00D, 2);
        do_cmd(2'b00, 2'd2, 2'd3, 32'h0, 0);

        // Reset while the command sits in CAPTURE: nothing may be written back.
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = rmw_enabled() ? 2'b10 : 2'b00;
        bus.cmd_addr_a = 2'd3;
        bus.cmd_addr_b = 2'd0;
        bus.cmd_data   = 32'h0000_0100;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_outputs("mid_reset");
        @(negedge clk);
        chk_reset_outputs("mid_reset_held");
        rst = 1'b0;
        do_cmd(2'b00, 2'd3, 2'd3, 32'h0, 0);

        for (int k = 0; k < 40; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = 2'($urandom_range(0, 3));
            r_b  = 2'($urandom_range(0, 3));
            r_d  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 4)))
                                               : 32'($urandom);
            do_cmd(r_op, r_a, r_b, r_d, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
